aurora_tx_arbiter: RTL and testbench
====================================

Name: aurora_tx_arbiter

Overview:
Packet-atomic round-robin arbiter that shares one Aurora 8B/10B channel's AXI-Stream TX port between P_REQ_NUM user sources.
- Sits between the user data generators/requesters and one channel's s_axi_tx_* input.
- Runs in that channel's user clock domain.
- Gates new packets on channel_up.
- Flushes a packet in flight if the link drops.

Parameters:
P_REQ_NUM, 2, number of requesting sources (2..8)
P_DATA_WIDTH, 32, tdata width per source
P_KEEP_WIDTH, 4, tkeep width per source (P_DATA_WIDTH/8)

Ports:
i_clk  in  1  channel user clock
i_rst  in  1  reset, asynchronous, active-high
i_channel_up  in  1  Aurora channel_up, synchronous to i_clk
s_axi_tx_tdata  in  P_REQ_NUM*P_DATA_WIDTH  source tdata, source k at bits [k*P_DATA_WIDTH +: P_DATA_WIDTH]
s_axi_tx_tkeep  in  P_REQ_NUM*P_KEEP_WIDTH  source tkeep, packed the same way
s_axi_tx_tlast  in  P_REQ_NUM  per-source tlast
s_axi_tx_tvalid  in  P_REQ_NUM  per-source tvalid
s_axi_tx_tready  out  P_REQ_NUM  per-source tready
m_axi_tx_tdata  out  P_DATA_WIDTH  to Aurora TX
m_axi_tx_tkeep  out  P_KEEP_WIDTH  to Aurora TX
m_axi_tx_tlast  out  1  to Aurora TX
m_axi_tx_tvalid  out  1  to Aurora TX
m_axi_tx_tready  in  1  from Aurora TX
o_grant  out  P_REQ_NUM  one-hot current owner, 0 when idle
o_busy  out  1  high in XFER or FLUSH

Behaviour:
Reset (async, i_rst=1):
- State = IDLE.
- o_grant = 0; o_busy = 0.
- All s_axi_tx_tready = 0; m_axi_tx_tvalid = 0; m_axi_tx_tlast = 0.
- m_axi_tx_tdata and m_axi_tx_tkeep = 0.
- Round-robin pointer = 0 (source 0 highest priority first).

FSM states: IDLE, XFER, FLUSH.

IDLE:
- No ready asserted.
- If i_channel_up=1 and any tvalid=1: pick the first requesting source at or after the pointer (wrapping modulo P_REQ_NUM).
- Register o_grant one-hot and go to XFER.
- Arbitration costs exactly 1 cycle. The first beat can transfer on the cycle after the request is seen.
- If i_channel_up=0: stay in IDLE regardless of requests.

XFER:
- Zero-latency combinational mux:
  - m_axi_tx_tdata/tkeep/tlast/tvalid = granted source's signals.
  - s_axi_tx_tready[g] = m_axi_tx_tready.
  - Non-granted tready = 0.
- Beat transfers when m_axi_tx_tvalid & m_axi_tx_tready.
- On transfer with tlast=1:
  - Pointer = (g+1) mod P_REQ_NUM.
  - o_grant = 0; go to IDLE.
  - No back-to-back grant; 1 idle cycle between packets.
- If i_channel_up falls mid-packet (before the tlast transfer): go to FLUSH on the next cycle.
- Simultaneous tlast transfer and channel_up fall: the packet counts as complete; go to IDLE.

FLUSH:
- m_axi_tx_tvalid forced 0.
- s_axi_tx_tready[g] = 1: discards the remaining beats of the granted source.
- On the discarded beat with tlast=1: pointer advances as in XFER, o_grant = 0, go to IDLE.
- FLUSH completes even if channel_up returns meanwhile.

General rules:
- Grant never changes mid-packet.
- A source deasserting tvalid mid-packet keeps the grant; stalling is legal.
- Source tvalid asserted with channel_up=0: held off (tready=0), no data lost.
- o_busy = (state != IDLE).
- Mid-operation reset: all outputs return to reset values immediately (asynchronously). The packet is truncated; no recovery is attempted.

Optional Feature:
Macro AURORA_ARB_CNT_EN.
- Defined, adds:
  - Output o_pkt_cnt, P_REQ_NUM*16 bits: per-source count of completed packets, incremented on the tlast transfer in XFER.
  - Output o_abort_cnt, 16 bits: incremented on each XFER->FLUSH entry.
  - All counters wrap at 16'hFFFF->0 and are cleared by i_rst.
- Undefined: these ports and the counter logic do not exist.

Test Plan:
1. Reset, i_channel_up=1, source 0 sends a 4-beat packet, m_tready=1 -> o_grant=01 one cycle after tvalid, then 4 beats out with data unchanged and tlast on beat 4, then o_grant=00.
2. Both sources continuously valid, 2-beat packets -> grants alternate 01,10,01,10 with one idle cycle between packets; the non-granted tready never goes high.
3. i_channel_up=0 with source 1 valid for 20 cycles -> m_tvalid=0 and s_tready=00 throughout; channel_up=1 -> grant 10 on the next cycle.
4. Source 0 mid 8-beat packet, channel_up drops after beat 3 -> m_tvalid=0 from the next cycle, beats 4..8 drained with s_tready[0]=1, FSM back in IDLE, pointer=1; with AURORA_ARB_CNT_EN, o_abort_cnt=1.
5. m_tready toggling 1,0,1,0 during a 6-beat packet -> exactly 6 transfers, no duplicated or dropped beats, s_tready[g] mirrors m_tready.
6. i_rst asserted mid-XFER -> o_grant, o_busy, m_tvalid and all s_tready drop to 0 immediately, without waiting for a clock edge; after release, source 0 is granted first.

Source files
------------

// File: rtl/aurora_tx_arbiter.sv
// aurora_tx_arbiter: packet-atomic round-robin arbiter that lets P_REQ_NUM
// AXI-Stream sources share one Aurora 8B/10B channel TX port. New packets are
// only started while channel_up is high. A packet caught by a link drop is
// drained from its source and discarded.
// Optional build macro AURORA_ARB_CNT_EN adds per-source completed-packet
// counters (o_pkt_cnt) and a link-drop abort counter (o_abort_cnt).
module aurora_tx_arbiter #(
    parameter int P_REQ_NUM    = 2,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_KEEP_WIDTH = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_channel_up,
    input  logic [P_REQ_NUM*P_DATA_WIDTH-1:0] s_axi_tx_tdata,
    input  logic [P_REQ_NUM*P_KEEP_WIDTH-1:0] s_axi_tx_tkeep,
    input  logic [P_REQ_NUM-1:0]              s_axi_tx_tlast,
    input  logic [P_REQ_NUM-1:0]              s_axi_tx_tvalid,
    output logic [P_REQ_NUM-1:0]              s_axi_tx_tready,
    output logic [P_DATA_WIDTH-1:0]           m_axi_tx_tdata,
    output logic [P_KEEP_WIDTH-1:0]           m_axi_tx_tkeep,
    output logic                              m_axi_tx_tlast,
    output logic                              m_axi_tx_tvalid,
    input  logic                              m_axi_tx_tready,
    output logic [P_REQ_NUM-1:0]              o_grant,
`ifdef AURORA_ARB_CNT_EN
    output logic [P_REQ_NUM*16-1:0]           o_pkt_cnt,
    output logic [15:0]                       o_abort_cnt,
`endif
    output logic                              o_busy
);

    localparam int PTR_W = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_FLUSH
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   gidx_q;
    logic [PTR_W-1:0]   pick_idx;
    logic [P_REQ_NUM-1:0] grant_q;
    logic               pick_found;
    int                 cand;
    logic               cur_valid;
    logic               cur_last;
    logic               xfer_done;
    logic               flush_done;
    logic               start_grant;

    assign cur_valid   = s_axi_tx_tvalid[gidx_q];
    assign cur_last    = s_axi_tx_tlast[gidx_q];
    assign xfer_done   = (state_q == ST_XFER) && cur_valid && m_axi_tx_tready && cur_last;
    assign flush_done  = (state_q == ST_FLUSH) && cur_valid && cur_last;
    assign start_grant = (state_q == ST_IDLE) && i_channel_up && pick_found;

    // Round-robin pick: scan from the highest offset down so the requester
    // closest to (at or after) the pointer is the one left selected.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = 0;
        for (int i = P_REQ_NUM - 1; i >= 0; i--) begin
            cand = int'(ptr_q) + i;
            if (cand >= P_REQ_NUM) begin
                cand = cand - P_REQ_NUM;
            end
            if (s_axi_tx_tvalid[cand]) begin
                pick_idx   = PTR_W'(cand);
                pick_found = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a completed tlast beat wins over a simultaneous link drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_grant) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (xfer_done) begin
                    state_d = ST_IDLE;
                end else if (!i_channel_up) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant and round-robin pointer: latched on arbitration, released and
    // advanced past the owner when its packet ends (sent or flushed).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else if (start_grant) begin
            grant_q <= P_REQ_NUM'(1) << pick_idx;
            gidx_q  <= pick_idx;
        end else if (xfer_done || flush_done) begin
            grant_q <= '0;
            ptr_q   <= (int'(gidx_q) == P_REQ_NUM - 1) ? '0 : gidx_q + PTR_W'(1);
        end
    end

    // Datapath: zero-latency mux of the owner in XFER, sink-only drain in FLUSH.
    always_comb begin
        m_axi_tx_tdata  = '0;
        m_axi_tx_tkeep  = '0;
        m_axi_tx_tlast  = 1'b0;
        m_axi_tx_tvalid = 1'b0;
        s_axi_tx_tready = '0;
        case (state_q)
            ST_XFER: begin
                m_axi_tx_tdata          = s_axi_tx_tdata[gidx_q*P_DATA_WIDTH +: P_DATA_WIDTH];
                m_axi_tx_tkeep          = s_axi_tx_tkeep[gidx_q*P_KEEP_WIDTH +: P_KEEP_WIDTH];
                m_axi_tx_tlast          = cur_last;
                m_axi_tx_tvalid         = cur_valid;
                s_axi_tx_tready[gidx_q] = m_axi_tx_tready;
            end
            ST_FLUSH: begin
                s_axi_tx_tready[gidx_q] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q != ST_IDLE);

`ifdef AURORA_ARB_CNT_EN
    logic [P_REQ_NUM*16-1:0] pkt_cnt_q;
    logic [15:0]             abort_cnt_q;

    // Statistics: packets sent per source and packets cut by a link drop;
    // both wrap naturally at 16 bits.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pkt_cnt_q   <= '0;
            abort_cnt_q <= '0;
        end else begin
            if (xfer_done) begin
                pkt_cnt_q[gidx_q*16 +: 16] <= pkt_cnt_q[gidx_q*16 +: 16] + 16'd1;
            end
            if ((state_q == ST_XFER) && (state_d == ST_FLUSH)) begin
                abort_cnt_q <= abort_cnt_q + 16'd1;
            end
        end
    end

    assign o_pkt_cnt   = pkt_cnt_q;
    assign o_abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// tb_aurora_tx_arbiter: directed scoreboard bench for aurora_tx_arbiter with
// two sources. Source beats are queued per source and replayed AXI-style;
// every beat expected on the Aurora side is queued in order and checked as
// it leaves the arbiter.
module tb_aurora_tx_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        ch_up;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic [1:0]  s_tlast;
    logic [1:0]  s_tvalid;
    logic [1:0]  s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_ready;
    logic [1:0]  o_grant;
    logic        o_busy;
`ifdef AURORA_ARB_CNT_EN
    logic [31:0] o_pkt_cnt;
    logic [15:0] o_abort_cnt;
`endif

    int    tests_run;
    int    tests_failed;
    int    xfer_cnt;
    logic  acc0;
    logic  acc1;
    logic  toggle_en;
    beat_t q0[$];
    beat_t q1[$];
    beat_t exp_q[$];
    beat_t exp_b;

    aurora_tx_arbiter #(
        .P_REQ_NUM   (2),
        .P_DATA_WIDTH(32),
        .P_KEEP_WIDTH(4)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_channel_up   (ch_up),
        .s_axi_tx_tdata (s_tdata),
        .s_axi_tx_tkeep (s_tkeep),
        .s_axi_tx_tlast (s_tlast),
        .s_axi_tx_tvalid(s_tvalid),
        .s_axi_tx_tready(s_tready),
        .m_axi_tx_tdata (m_tdata),
        .m_axi_tx_tkeep (m_tkeep),
        .m_axi_tx_tlast (m_tlast),
        .m_axi_tx_tvalid(m_tvalid),
        .m_axi_tx_tready(m_ready),
        .o_grant        (o_grant),
`ifdef AURORA_ARB_CNT_EN
        .o_pkt_cnt      (o_pkt_cnt),
        .o_abort_cnt    (o_abort_cnt),
`endif
        .o_busy         (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    // Present the head of each source queue on the source-side AXI inputs.
    task automatic driveSources();
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        if (q0.size() > 0) begin
            s_tvalid[0]     = 1'b1;
            s_tdata[31:0]   = q0[0].data;
            s_tkeep[3:0]    = q0[0].keep;
            s_tlast[0]      = q0[0].last;
        end
        if (q1.size() > 0) begin
            s_tvalid[1]     = 1'b1;
            s_tdata[63:32]  = q1[0].data;
            s_tkeep[7:4]    = q1[0].keep;
            s_tlast[1]      = q1[0].last;
        end
    endtask

    // Queue one packet on a source; the first n_exp beats are expected out.
    task automatic applyStimulus(input int src, input int pkt, input int beats, input int n_exp);
        beat_t b;
        for (int i = 0; i < beats; i++) begin
            b.data = 32'hA000_0000 | (32'(src) << 16) | (32'(pkt) << 8) | 32'(i);
            b.keep = (i == beats - 1) ? 4'h7 : 4'hF;
            b.last = (i == beats - 1);
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
            if (i < n_exp) exp_q.push_back(b);
        end
    endtask

    task automatic waitUntilIdle(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            nextCycle();
            if (!o_busy && q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput(tag, 64'(done), 64'd1);
    endtask

    task automatic waitGrant(input string tag, input logic [1:0] expected, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            nextCycle();
            if (o_grant != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_seen"}, 64'(seen), 64'd1);
        checkOutput(tag, 64'(o_grant), 64'(expected));
    endtask

    // Source-side handshake bookkeeping: beats accepted at the coming edge
    // are retired just after it and the next head is presented.
    always begin
        @(posedge clk);
        #1;
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        if (toggle_en) m_ready = ~m_ready;
        driveSources();
    end

    // Aurora-side monitor: score every transferred beat and watch that a
    // source without the grant is never handed tready.
    always @(negedge clk) begin
        acc0 = s_tvalid[0] && s_tready[0];
        acc1 = s_tvalid[1] && s_tready[1];
        if (m_tvalid && m_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $error("[TB] FAIL unexpected_beat: observed %0h expected no beat", m_tdata);
            end else begin
                exp_b = exp_q.pop_front();
                checkOutput("beat", 64'({m_tdata, m_tkeep, m_tlast}),
                            64'({exp_b.data, exp_b.keep, exp_b.last}));
            end
        end
        checkOutput("nongrant_tready", 64'(s_tready & ~o_grant), 64'd0);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed time limit expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] prev_g;
        logic [1:0] exp_g;
        int         starts;
        int         gap;
        logic       found;

        tests_run    = 0;
        tests_failed = 0;
        xfer_cnt     = 0;
        acc0         = 1'b0;
        acc1         = 1'b0;
        toggle_en    = 1'b0;
        rst          = 1'b1;
        ch_up        = 1'b1;
        m_ready      = 1'b1;
        driveSources();
        repeat (3) nextCycle();

        // Reset state
        checkOutput("rst_grant",  64'(o_grant),  64'd0);
        checkOutput("rst_busy",   64'(o_busy),   64'd0);
        checkOutput("rst_mvalid", 64'(m_tvalid), 64'd0);
        checkOutput("rst_mlast",  64'(m_tlast),  64'd0);
        checkOutput("rst_mdata",  64'({m_tdata, m_tkeep}), 64'd0);
        checkOutput("rst_sready", 64'(s_tready), 64'd0);
        rst = 1'b0;
        nextCycle();

        // 1: single 4-beat packet from source 0
        applyStimulus(0, 1, 4, 4);
        nextCycle();
        checkOutput("t1_valid_seen", 64'(s_tvalid[0]), 64'd1);
        checkOutput("t1_no_grant_yet", 64'(o_grant), 64'd0);
        nextCycle();
        checkOutput("t1_grant", 64'(o_grant), 64'h1);
        checkOutput("t1_busy",  64'(o_busy),  64'd1);
        waitUntilIdle("t1_drained", 20);
        checkOutput("t1_grant_released", 64'(o_grant), 64'd0);

        // 2: both sources busy with 2-beat packets, grants must alternate
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        for (int p = 0; p < 4; p++) begin
            applyStimulus(0, 16 + p, 2, 2);
            applyStimulus(1, 16 + p, 2, 2);
        end
        prev_g = 2'b00;
        exp_g  = 2'b01;
        starts = 0;
        gap    = 0;
        for (int i = 0; i < 80; i++) begin
            nextCycle();
            if (o_grant != 2'b00 && prev_g == 2'b00) begin
                checkOutput("t2_rr_grant", 64'(o_grant), 64'(exp_g));
                if (starts > 0) checkOutput("t2_idle_gap", 64'(gap), 64'd1);
                exp_g  = {exp_g[0], exp_g[1]};
                starts = starts + 1;
                gap    = 0;
            end else if (o_grant == 2'b00) begin
                gap = gap + 1;
            end
            prev_g = o_grant;
            if (starts == 8 && o_grant == 2'b00) break;
        end
        checkOutput("t2_packet_count", 64'(starts), 64'd8);
        waitUntilIdle("t2_drained", 20);
`ifdef AURORA_ARB_CNT_EN
        checkOutput("t2_pkt_cnt", 64'(o_pkt_cnt), 64'h0004_0004);
`endif

        // 3: requests held off while the channel is down
        ch_up = 1'b0;
        applyStimulus(1, 32, 2, 2);
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            checkOutput("t3_mvalid_down", 64'(m_tvalid), 64'd0);
            checkOutput("t3_sready_down", 64'(s_tready), 64'd0);
        end
        ch_up = 1'b1;
        nextCycle();
        checkOutput("t3_grant_on_up", 64'(o_grant), 64'h2);
        waitUntilIdle("t3_drained", 20);

        // 4: link drops during beat 3 of an 8-beat packet
        applyStimulus(0, 48, 8, 3);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            if (m_tvalid && m_tdata == 32'hA000_3002) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("t4_beat3_seen", 64'(found), 64'd1);
        ch_up = 1'b0;
        nextCycle();
        checkOutput("t4_flush_mvalid", 64'(m_tvalid),    64'd0);
        checkOutput("t4_flush_sready", 64'(s_tready[0]), 64'd1);
        checkOutput("t4_flush_busy",   64'(o_busy),      64'd1);
        waitUntilIdle("t4_flushed", 20);
        checkOutput("t4_grant_released", 64'(o_grant), 64'd0);
`ifdef AURORA_ARB_CNT_EN
        checkOutput("t4_abort_cnt", 64'(o_abort_cnt), 64'd1);
`endif
        ch_up = 1'b1;
        applyStimulus(1, 64, 1, 1);
        applyStimulus(0, 64, 1, 1);
        waitGrant("t4_ptr_after_flush", 2'b10, 10);
        waitUntilIdle("t4_drained", 20);

        // 5: sink backpressure toggling during a 6-beat packet
        xfer_cnt  = 0;
        applyStimulus(0, 80, 6, 6);
        toggle_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            nextCycle();
            if (o_grant == 2'b01) checkOutput("t5_sready_mirror", 64'(s_tready[0]), 64'(m_ready));
            if (!o_busy && q0.size() == 0) break;
        end
        toggle_en = 1'b0;
        m_ready   = 1'b1;
        checkOutput("t5_transfers", 64'(xfer_cnt), 64'd6);
        waitUntilIdle("t5_drained", 20);

        // 6: asynchronous reset in the middle of a packet
        applyStimulus(1, 96, 4, 4);
        waitGrant("t6_grant_before_rst", 2'b10, 10);
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_grant",  64'(o_grant),  64'd0);
        checkOutput("t6_rst_busy",   64'(o_busy),   64'd0);
        checkOutput("t6_rst_mvalid", 64'(m_tvalid), 64'd0);
        checkOutput("t6_rst_sready", 64'(s_tready), 64'd0);
        nextCycle();
        q0.delete();
        q1.delete();
        exp_q.delete();
        driveSources();
        rst = 1'b0;
        nextCycle();
        applyStimulus(0, 112, 1, 1);
        applyStimulus(1, 112, 1, 1);
        waitGrant("t6_first_after_rst", 2'b01, 10);
        waitUntilIdle("t6_drained", 20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
